// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_decoder
// Purpose  : Passive monitor of a multiplexed active-low 7-segment bus that
//            rebuilds the four displayed BCD digits and flags bus faults.
//            Optional error counter enabled by SSD_DECODE_ERR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [6:0]  cathodes,
  output logic [15:0] digit_data,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic        contention,
  output logic        stale
`ifdef SSD_DECODE_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        c_settle  = 8'(SETTLE_CYCLES);
  localparam logic [c_to_w-1:0] c_timeout = c_to_w'(TIMEOUT_CYCLES);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

  // Returns {error, nibble}; anything outside the ten BCD glyphs is an error.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] v;
    case (seg)
      7'h40:   v = 5'h00;
      7'h79:   v = 5'h01;
      7'h24:   v = 5'h02;
      7'h30:   v = 5'h03;
      7'h19:   v = 5'h04;
      7'h12:   v = 5'h05;
      7'h02:   v = 5'h06;
      7'h78:   v = 5'h07;
      7'h00:   v = 5'h08;
      7'h10:   v = 5'h09;
      default: v = 5'h1F;
    endcase
    return v;
  endfunction

  logic [3:0]        r_a_s1, r_a_s;
  logic [6:0]        r_c_s1, r_c_s;
  logic              r_prev_sel;
  logic [1:0]        r_prev_idx;
  logic [6:0]        r_prev_c;
  logic [7:0]        r_stab;
  logic [15:0]       r_shadow;
  logic [3:0]        r_shadow_err;
  logic [3:0]        r_mask;
  logic [c_to_w-1:0] r_to;

  logic              w_sel, w_blank, w_cont, w_same, w_capture, w_frame_done;
  logic [1:0]        w_idx;
  logic [7:0]        w_stab_next;
  logic [4:0]        w_dec;
  logic [15:0]       w_shadow_nxt;
  logic [3:0]        w_shadow_err_nxt;
  logic [3:0]        w_mask_nxt;

  always_comb begin
    w_idx = 2'd0;
    w_sel = 1'b1;
    case (r_a_s)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_sel = 1'b0;
    endcase
  end

  assign w_blank = (r_a_s == 4'hF);
  assign w_cont  = !w_sel && !w_blank;
  assign w_same  = r_prev_sel && (r_prev_idx == w_idx) && (r_prev_c == r_c_s);

  // Capture fires only on the transition into SETTLE_CYCLES, so a long dwell
  // sitting at saturation never recaptures.
  always_comb begin
    w_stab_next = 8'd0;
    w_capture   = 1'b0;
    if (w_sel) begin
      if (w_same) begin
        if (r_stab < c_settle) begin
          w_stab_next = r_stab + 8'd1;
          w_capture   = ((r_stab + 8'd1) == c_settle);
        end else begin
          w_stab_next = r_stab;
        end
      end else begin
        w_stab_next = 8'd1;
        w_capture   = (c_settle == 8'd1);
      end
    end
  end

  assign w_dec = f_decode(r_c_s);

  always_comb begin
    w_shadow_nxt     = r_shadow;
    w_shadow_err_nxt = r_shadow_err;
    w_mask_nxt       = r_mask;
    if (w_capture) begin
      w_shadow_nxt[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_shadow_err_nxt[w_idx]           = w_dec[4];
      w_mask_nxt[w_idx]                 = 1'b1;
    end
  end

  assign w_frame_done = w_capture && (w_mask_nxt == 4'hF);
  assign stale        = (r_to >= c_timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_s1       <= 4'hF;
      r_a_s        <= 4'hF;
      r_c_s1       <= 7'h00;
      r_c_s        <= 7'h00;
      r_prev_sel   <= 1'b0;
      r_prev_idx   <= 2'd0;
      r_prev_c     <= 7'h00;
      r_stab       <= 8'd0;
      r_shadow     <= 16'h0000;
      r_shadow_err <= 4'h0;
      r_mask       <= 4'h0;
      r_to         <= '0;
      digit_data   <= 16'h0000;
      digit_err    <= 4'h0;
      frame_valid  <= 1'b0;
      contention   <= 1'b0;
    end else begin
      r_a_s1       <= anodes;
      r_a_s        <= r_a_s1;
      r_c_s1       <= cathodes;
      r_c_s        <= r_c_s1;
      r_prev_sel   <= w_sel;
      r_prev_idx   <= w_idx;
      r_prev_c     <= r_c_s;
      r_stab       <= w_stab_next;
      r_shadow     <= w_shadow_nxt;
      r_shadow_err <= w_shadow_err_nxt;
      r_mask       <= w_frame_done ? 4'h0 : w_mask_nxt;
      frame_valid  <= w_frame_done;
      if (w_frame_done) begin
        digit_data <= w_shadow_nxt;
        digit_err  <= w_shadow_err_nxt;
      end
      if (w_cont) begin
        contention <= 1'b1;
      end
      if (w_capture) begin
        r_to <= '0;
      end else if (r_to < c_timeout) begin
        r_to <= r_to + c_to_one;
      end
    end
  end

`ifdef SSD_DECODE_ERR_COUNT_EN
  logic r_prev_cont;
  logic w_err_event;

  // Bad frame and new contention in one cycle count as a single event.
  assign w_err_event = (w_frame_done && (|w_shadow_err_nxt)) || (w_cont && !r_prev_cont);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_cont <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      r_prev_cont <= w_cont;
      if (w_err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Passive receiver for the multiplexed seven-segment bus. It samples the active-low anode/cathode lines driven by the display driver and reconstructs the four displayed BCD digits as a 16-bit word. It flags illegal segment patterns and bus contention, and reports a stale display. It sits on the display pins as a self-check and loopback monitor for the stopwatch datapath, clocked by the same divided clock as the driver.

## Interface
- SETTLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a digit (1..255).
- TIMEOUT_CYCLES, default 2000: cycles without any digit capture before `stale` asserts (1..2^20-1).
- clk  in  1  sampling clock (same domain as the display driver).
- reset  in  1  asynchronous, active-low reset.
- anodes  in  4  display anodes, active low; bit i selects digit i.
- cathodes  in  7  segments {g,f,e,d,c,b,a}, active low.
- digit_data  out  16  recovered BCD; digit i in bits [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when `digit_data` updates.
- digit_err  out  4  per-digit illegal-pattern flags for the last frame.
- contention  out  1  sticky; set when more than one anode is low.
- stale  out  1  high while no capture has occurred for TIMEOUT_CYCLES.

## Operation
- Inputs pass through a 2-flop synchronizer. All logic below uses the synchronized values `a_s` and `c_s`.
- Sample classification:
  - Exactly one bit of `a_s` low: select, index = that bit.
  - All high: blank gap.
  - Two or more low: contention. Sets `contention`, resets the stability counter, captures nothing.
- Stability counter (8-bit):
  - Increments while the select index and `c_s` are identical to the previous sample.
  - Restarts at 1 on any change, and at 0 on a blank gap.
  - Saturates at SETTLE_CYCLES.
- Capture happens on the cycle the counter reaches SETTLE_CYCLES, at most once per anode dwell.
- Decode table (`c_s`, hex) to nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - Any other pattern, including 7F (all off), yields nibble F and sets the digit's error bit.
- Captured nibbles and error bits go into a shadow register, and the digit's bit is set in a 4-bit capture mask.
- When the mask becomes 1111:
  - shadow → `digit_data`, shadow errors → `digit_err`.
  - Pulse `frame_valid`, clear the mask.
  - Recapturing an already-set digit before the frame completes overwrites its shadow entry.
- Timeout counter:
  - Clears on every capture, otherwise increments and saturates.
  - `stale` = counter ≥ TIMEOUT_CYCLES.
- `contention` clears only on reset.

## Timing
- Reset values: `digit_data` = 0000, `frame_valid` = 0, `digit_err` = 0000, `contention` = 0, `stale` = 0. All internal counters, the mask and the synchronizers are cleared (synchronizer anodes reset to 1111).
- Latency from a pin change to the first synchronized sample: 2 cycles.
- A stable dwell of N ≥ SETTLE_CYCLES samples captures on the SETTLE_CYCLES-th sample, i.e. pin change + 2 + SETTLE_CYCLES − 1 cycles.
- `frame_valid` and the new `digit_data` appear together, 1 cycle after the capture that completes the mask.
- A dwell shorter than SETTLE_CYCLES is discarded.
- Capture and timeout on the same cycle: the capture wins, the counter clears and `stale` does not assert.
- `stale` deasserts the cycle after the next capture.
- Reset asserted mid-frame: partial shadow contents are discarded and the next frame starts from an empty mask.

## Configuration
- `SSD_DECODE_ERR_COUNT_EN` defined:
  - Adds output port `err_count` (8 bits, reset 0).
  - Increments once per frame that has any `digit_err` bit set, and once per new contention sample (rising edge of the contention condition).
  - Saturates at 255. If both events occur in the same cycle it increments by 1.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Drive a 1234 scan (digit 0 = 4, … digit 3 = 1), dwell 10 cycles each, 1-cycle blank between digits → `frame_valid` pulses, `digit_data` = 16'h1234, `digit_err` = 0000.
- Same scan with a dwell of 3 cycles and SETTLE_CYCLES = 4 → no `frame_valid`. After 2000 cycles `stale` = 1. Restoring a 10-cycle dwell clears `stale` after the first capture.
- Digit 2 cathodes = 7'h7F, others showing 5 → `digit_data` = 16'h5F55, `digit_err` = 0100, and `err_count` = 1 when the macro is enabled.
- Anodes = 4'b1100 for 6 cycles mid-scan → `contention` = 1 and stays set. Subsequent clean scans still produce correct frames.
- Reset pulsed after 2 of 4 digits are captured, then a full 9876 scan → exactly one `frame_valid`, `digit_data` = 16'h9876.
- A cathode glitch lasting 1 cycle within a 10-cycle dwell, SETTLE_CYCLES = 4 → the digit is still captured once with the correct value. Capture time is measured from the end of the glitch.
